buf_ctl_xpose: RTL and testbench

- Parametrised corner-turn buffer for the 3D FFT datapath: accepts one full D×D×D cube of complex samples, LANES per beat, from an FFT stage. Plays it back in transposed order for the next dimension's FFT.
- Internal counters generate all addresses; it supersedes external row/col/dep indexing.
- Sits between consecutive 1D FFT engines; one URAM-mapped bank per lane.

---
 rtl/fft3d_pkg.sv | 32 +++
 rtl/xpose_addr_gen.sv | 84 ++++++++
 rtl/buf_ctl_xpose.sv | 158 +++++++++++++++
 tb/tb_buf_ctl_xpose.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fft3d_pkg.sv
// Shared types and helpers for the 3D FFT corner-turn buffer.
// Holds the controller state encoding, default geometry and address arithmetic.
package fft3d_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } xpose_state_e;

  localparam int DEF_DW      = 64;
  localparam int DEF_CUBIC_D = 96;
  localparam int DEF_LANES   = 2;

  // Beats needed to carry one full D x D x D cube.
  function automatic int unsigned calc_nbeat(input int unsigned edge_len, input int unsigned lanes);
    return (edge_len * edge_len * edge_len) / lanes;
  endfunction

  // Address/counter width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

  // Bank address of beat (r, d, c); r indexes groups of LANES rows.
  function automatic int unsigned bank_addr(input int unsigned r, input int unsigned d,
                                            input int unsigned c, input int unsigned edge_len);
    return (r * edge_len * edge_len) + (d * edge_len) + c;
  endfunction

endpackage

// File: rtl/xpose_addr_gen.sv
// Three nested beat counters (row group, depth, column) with selectable loop order.
// order=0 walks c fastest, then d, then r; order=1 walks r fastest, then c, then d.
module xpose_addr_gen
  import fft3d_pkg::*;
#(
  parameter int CUBIC_D = DEF_CUBIC_D,
  parameter int LANES   = DEF_LANES,
  parameter int AW      = clog2_min1(calc_nbeat(DEF_CUBIC_D, DEF_LANES))
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          advance,
  input  logic          order,
  output logic          last,
  output logic [AW-1:0] addr
);

  localparam int NROW = CUBIC_D / LANES;
  localparam int CW   = clog2_min1(CUBIC_D);
  localparam int RW   = clog2_min1(NROW);
  localparam logic [CW-1:0] C_MAX = CW'(CUBIC_D - 1);
  localparam logic [RW-1:0] R_MAX = RW'(NROW - 1);

  logic [CW-1:0] c_r;
  logic [CW-1:0] d_r;
  logic [RW-1:0] r_r;
  logic          c_max_s;
  logic          d_max_s;
  logic          r_max_s;
  logic          inc_c_s;
  logic          inc_d_s;
  logic          inc_r_s;

  assign c_max_s = (c_r == C_MAX);
  assign d_max_s = (d_r == C_MAX);
  assign r_max_s = (r_r == R_MAX);

  // Carry chain: a counter steps when every faster counter sits at its maximum.
  always_comb begin
    inc_c_s = 1'b0;
    inc_d_s = 1'b0;
    inc_r_s = 1'b0;
    case (order)
      1'b0: begin
        inc_c_s = advance;
        inc_d_s = advance & c_max_s;
        inc_r_s = advance & c_max_s & d_max_s;
      end
      1'b1: begin
        inc_r_s = advance;
        inc_c_s = advance & r_max_s;
        inc_d_s = advance & r_max_s & c_max_s;
      end
      default: begin
        inc_c_s = 1'b0;
        inc_d_s = 1'b0;
        inc_r_s = 1'b0;
      end
    endcase
  end

  // Counter registers; each wraps to zero at its maximum so a full pass ends at all-zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      c_r <= '0;
      d_r <= '0;
      r_r <= '0;
    end else begin
      if (inc_c_s) begin
        c_r <= c_max_s ? '0 : c_r + CW'(1);
      end
      if (inc_d_s) begin
        d_r <= d_max_s ? '0 : d_r + CW'(1);
      end
      if (inc_r_s) begin
        r_r <= r_max_s ? '0 : r_r + RW'(1);
      end
    end
  end

  assign last = c_max_s & d_max_s & r_max_s;
  assign addr = AW'(bank_addr(32'(r_r), 32'(d_r), 32'(c_r), CUBIC_D));

endmodule

// File: rtl/buf_ctl_xpose.sv
// Corner-turn buffer: captures one D x D x D cube, LANES samples per beat, into one bank
// per lane and replays it either in arrival order or row-fastest (transposed) order.
module buf_ctl_xpose
  import fft3d_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int CUBIC_D = DEF_CUBIC_D,
  parameter int LANES   = DEF_LANES,
  parameter int RD_LAT  = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] in_data,
  output logic                out_valid,
  output logic [LANES*DW-1:0] out_data,
  output logic                busy,
  output logic                done
);

  localparam int NBEAT = calc_nbeat(CUBIC_D, LANES);
  localparam int AW    = clog2_min1(NBEAT);

  xpose_state_e      state_r;
  xpose_state_e      state_s;
  logic              mode_r;
  logic              accept_s;
  logic              issue_s;
  logic              advance_s;
  logic              order_s;
  logic              last_s;
  logic [AW-1:0]     addr_s;
  logic [RD_LAT-1:0] vld_pipe_r;
  logic [RD_LAT-1:0] fin_pipe_r;

  // in_ready is only ever high in IDLE/WRITE, so this is the sole write qualifier.
  assign accept_s  = in_valid & in_ready;
  assign issue_s   = (state_r == ST_READ);
  assign advance_s = accept_s | issue_s;
  assign order_s   = issue_s ? mode_r : 1'b0;

  xpose_addr_gen #(
    .CUBIC_D (CUBIC_D),
    .LANES   (LANES),
    .AW      (AW)
  ) u_addr_gen (
    .clock   (clock),
    .reset   (reset),
    .advance (advance_s),
    .order   (order_s),
    .last    (last_s),
    .addr    (addr_s)
  );

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = last_s ? ST_READ : ST_WRITE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (accept_s && last_s) begin
          state_s = ST_READ;
        end else begin
          state_s = ST_WRITE;
        end
      end
      ST_READ: begin
        if (last_s) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (fin_pipe_r[RD_LAT-1]) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, mode latch and registered status outputs derived from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      mode_r   <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_r  <= state_s;
      in_ready <= (state_s == ST_IDLE) || (state_s == ST_WRITE);
      busy     <= (state_s != ST_IDLE);
      if ((state_r == ST_IDLE) && accept_s) begin
        mode_r <= mode;
      end
    end
  end

  // Read-valid and final-beat tags travel alongside the bank read pipeline.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe_r <= '0;
      fin_pipe_r <= '0;
    end else begin
      vld_pipe_r[0] <= issue_s;
      fin_pipe_r[0] <= issue_s & last_s;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe_r[i] <= vld_pipe_r[i-1];
        fin_pipe_r[i] <= fin_pipe_r[i-1];
      end
    end
  end

  assign out_valid = vld_pipe_r[RD_LAT-1];
  assign done      = fin_pipe_r[RD_LAT-1];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DW-1:0] mem_r  [NBEAT];
    logic [DW-1:0] pipe_r [RD_LAT];

    // Bank write port; contents survive reset.
    always_ff @(posedge clock) begin
      if (accept_s) begin
        mem_r[addr_s] <= in_data[k*DW +: DW];
      end
    end

    // Bank read register followed by the remaining output register stages.
    always_ff @(posedge clock) begin
      if (reset) begin
        for (int i = 0; i < RD_LAT; i++) begin
          pipe_r[i] <= '0;
        end
      end else begin
        pipe_r[0] <= mem_r[addr_s];
        for (int i = 1; i < RD_LAT; i++) begin
          pipe_r[i] <= pipe_r[i-1];
        end
      end
    end

    assign out_data[k*DW +: DW] = pipe_r[RD_LAT-1];
  end

endmodule

// File: tb/tb_buf_ctl_xpose.sv
// Directed bench for buf_ctl_xpose with a 4x4x4 cube, two lanes and two-cycle read latency.
module tb_buf_ctl_xpose;

  localparam int DW     = 16;
  localparam int D      = 4;
  localparam int LANES  = 2;
  localparam int RD_LAT = 2;
  localparam int NB     = 32;

  logic                clock = 1'b0;
  logic                reset;
  logic                mode;
  logic                in_valid;
  logic                in_ready;
  logic [LANES*DW-1:0] in_data;
  logic                out_valid;
  logic [LANES*DW-1:0] out_data;
  logic                busy;
  logic                done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [31:0] first_beats [2];

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  buf_ctl_xpose #(
    .DW      (DW),
    .CUBIC_D (D),
    .LANES   (LANES),
    .RD_LAT  (RD_LAT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Beat for row group r at (d, c): lane k holds element (2r+k)*16 + d*4 + c.
  function automatic logic [31:0] elem_beat(input int r, input int d, input int c);
    logic [15:0] l0;
    logic [15:0] l1;
    l0 = 16'((2 * r) * 16 + d * 4 + c);
    l1 = 16'((2 * r + 1) * 16 + d * 4 + c);
    return {l1, l0};
  endfunction

  function automatic logic [31:0] wr_beat(input int n);
    return elem_beat(n / 16, (n / 4) % 4, n % 4);
  endfunction

  // Transposed order: r fastest, then c, then d.
  function automatic logic [31:0] exp_beat(input int n, input logic m);
    if (m) return elem_beat(n % 2, n / 8, (n / 2) % 4);
    return wr_beat(n);
  endfunction

  task automatic do_cube(input logic m, input bit bubbles, input bit junk, input bit toggle,
                         input int rst_beat, input bit chk_total);
    int wb = 0;
    int ob = 0;
    int rc = 0;
    int guard = 0;
    int t0 = 0;
    bit aborted = 1'b0;
    while (wb < NB && guard < 200) begin
      @(negedge clock);
      guard++;
      check("wr_in_ready", 64'(in_ready), 64'd1);
      in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = wr_beat(wb);
      mode     = (toggle && wb > 0) ? ~m : m;
      if (in_valid && in_ready) begin
        if (wb == 0) t0 = cyc;
        wb++;
      end
    end
    check("wr_beats", 64'(wb), 64'(NB));
    while (!aborted && ob < NB && rc < NB + RD_LAT + 8) begin
      @(negedge clock);
      in_valid = junk;
      in_data  = junk ? $urandom : 32'd0;
      mode     = junk ? ~m : m;
      if (rc == 0) begin
        check("rd_in_ready", 64'(in_ready), 64'd0);
        check("rd_busy", 64'(busy), 64'd1);
      end
      if (out_valid) begin
        if (ob == 0) check("ov_latency", 64'(rc), 64'(RD_LAT));
        if (ob < 2) first_beats[ob] = out_data;
        check("out_data", 64'(out_data), 64'(exp_beat(ob, m)));
        check("done", 64'(done), 64'(ob == NB - 1));
        if (chk_total && ob == NB - 1) check("total_cycles", 64'(cyc - t0 + 1), 64'(2 * NB + RD_LAT));
        if (ob == rst_beat) begin
          reset    = 1'b1;
          in_valid = 1'b0;
          @(negedge clock);
          check("rst_out_valid", 64'(out_valid), 64'd0);
          check("rst_done", 64'(done), 64'd0);
          check("rst_in_ready", 64'(in_ready), 64'd0);
          reset = 1'b0;
          @(negedge clock);
          check("rel_busy", 64'(busy), 64'd0);
          check("rel_in_ready", 64'(in_ready), 64'd1);
          for (int i = 0; i < 4; i++) begin
            check("rel_out_valid", 64'(out_valid), 64'd0);
            check("rel_done", 64'(done), 64'd0);
            @(negedge clock);
          end
          aborted = 1'b1;
        end
        ob++;
      end else begin
        check("idle_done", 64'(done), 64'd0);
      end
      rc++;
    end
    if (!aborted) begin
      check("rd_beats", 64'(ob), 64'(NB));
      @(negedge clock);
      in_valid = 1'b0;
      check("end_busy", 64'(busy), 64'd0);
      check("end_in_ready", 64'(in_ready), 64'd1);
      check("end_out_valid", 64'(out_valid), 64'd0);
    end
  endtask

  initial begin
    reset    = 1'b1;
    mode     = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clock);
    check("rst_in_ready0", 64'(in_ready), 64'd0);
    check("rst_out_valid0", 64'(out_valid), 64'd0);
    check("rst_out_data0", 64'(out_data), 64'd0);
    check("rst_busy0", 64'(busy), 64'd0);
    check("rst_done0", 64'(done), 64'd0);
    reset = 1'b0;

    do_cube(1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    check("m1_beat0", 64'(first_beats[0]), 64'h0000_0000_0010_0000);
    check("m1_beat1", 64'(first_beats[1]), 64'h0000_0000_0030_0020);
    do_cube(1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b1);
    do_cube(1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    do_cube(1'b0, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    do_cube(1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0);
    do_cube(1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b1);
    do_cube(1'b1, 1'b0, 1'b0, 1'b0, 10, 1'b0);
    do_cube(1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    do_cube(1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    do_cube(1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
